// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling constants and the
// clock divider helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t START     = 3'd1;
    localparam state_t DATA      = 3'd2;
    localparam state_t STOP      = 3'd3;
    localparam state_t WAIT_IDLE = 3'd4;

    localparam int unsigned OS_RATE    = 16;
    localparam int unsigned MID_SAMPLE = 8;

    function automatic int unsigned os_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned rate);
        return clk_freq / (baud * rate);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Serial line plus host-side rdy/rdy_clr handshake of the oversampling receiver.
interface uart_rx_os_if;

    logic       rx;
    logic       rdy_clr;
    logic [7:0] data_out;
    logic       rdy;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx, rdy_clr,
        input  data_out, rdy, busy, frame_err, overrun
    );

    modport slave (
        input  rx, rdy_clr,
        output data_out, rdy, busy, frame_err, overrun
    );

endinterface

// File: rtl/uart_os_tick.sv
// Free-running tick generator: one-cycle pulse every DIV clocks.
module uart_os_tick #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    if (DIV < 1) begin : gen_div_check
        $error("uart_os_tick: DIV must be at least 1");
    end

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per data bit,
// sticky framing-error and overrun flags, and a rdy/rdy_clr host handshake.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OS_DIV   = os_div(CLK_FREQ, BAUD, OS_RATE)
) (
    input logic         clk,
    input logic         rst,
    uart_rx_os_if.slave bus
);

    localparam logic [3:0] MID     = 4'(MID_SAMPLE);
    localparam logic [3:0] SMP_A   = MID - 4'd1;
    localparam logic [3:0] SMP_C   = MID + 4'd1;
    localparam logic [3:0] LAST_SC = 4'(OS_RATE - 1);

    logic       rx_meta_q, rxs;
    logic       tick;
    state_t     state_q, state_d;
    logic [3:0] sc_q, sc_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] smp_q, smp_d;
    logic [7:0] data_q, data_d;
    logic       rdy_q, rdy_d;
    logic       fe_q, fe_d;
    logic       ov_q, ov_d;
    logic       frame_ok, frame_bad;
    logic       maj;

    uart_os_tick #(
        .DIV (OS_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Synchronizer resets to the idle level so reset release cannot fake a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rxs       <= rx_meta_q;
        end
    end

    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        smp_d     = smp_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (tick) begin
            sc_d = sc_q + 4'd1;
            case (state_q)
                IDLE: begin
                    sc_d = '0;
                    if (!rxs) state_d = START;
                end
                START: begin
                    if (sc_q == MID) begin
                        sc_d    = '0;
                        bit_d   = '0;
                        state_d = rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sc_q == SMP_A) smp_d[0] = rxs;
                    if (sc_q == MID)   smp_d[1] = rxs;
                    if (sc_q == SMP_C) smp_d[2] = rxs;
                    if (sc_q == LAST_SC) begin
                        sc_d  = '0;
                        sh_d  = {maj, sh_q[7:1]};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = STOP;
                    end
                end
                STOP: begin
                    if (sc_q == MID) begin
                        sc_d = '0;
                        if (rxs) begin
                            frame_ok = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            frame_bad = 1'b1;
                            state_d   = WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    sc_d = '0;
                    if (rxs) state_d = IDLE;
                end
                default: begin
                    sc_d    = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // A frame landing together with rdy_clr is accepted rather than counted as overrun.
    always_comb begin
        data_d = data_q;
        rdy_d  = rdy_q;
        fe_d   = fe_q;
        ov_d   = ov_q;
        if (bus.rdy_clr) begin
            rdy_d = 1'b0;
            fe_d  = 1'b0;
            ov_d  = 1'b0;
        end
        if (frame_ok) begin
            if (!rdy_q || bus.rdy_clr) begin
                data_d = sh_q;
                rdy_d  = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end
        if (frame_bad) fe_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sc_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            smp_q   <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = fe_q;
    assign bus.overrun   = ov_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames push expected results, a monitor
// pops and compares whenever rdy/flags rise or data_out changes.
`timescale 1ns/1ps
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ = 32_000_000;
    localparam int unsigned BAUD     = 1_000_000;
    localparam int          BIT_CLKS = 32;

    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic       fe;
        logic       ov;
        int         start;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os_if bus ();

    uart_rx_os #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic [7:0] ed,
                              input logic er, input logic ef, input logic eo);
        exp_t e;
        @(negedge clk);
        e.data  = ed;
        e.rdy   = er;
        e.fe    = ef;
        e.ov    = eo;
        e.start = cyc;
        q.push_back(e);
        bus.rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        bus.rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.rdy_clr = 1'b1;
        @(negedge clk);
        bus.rdy_clr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, q.size(), 0);
    endtask

    // Monitor: any rising flag or data_out change is one DUT response.
    initial begin : monitor
        logic [7:0] pd;
        logic       pr, pf, po, ev;
        exp_t       e;
        int         lat;
        pd = '0; pr = 1'b0; pf = 1'b0; po = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pd = '0; pr = 1'b0; pf = 1'b0; po = 1'b0;
            end else begin
                ev = (bus.rdy && !pr) || (bus.frame_err && !pf) || (bus.overrun && !po) ||
                     (bus.data_out != pd);
                if (ev) begin
                    if (q.size() == 0) begin
                        check("unexpected_response_queue", q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        lat = cyc - e.start;
                        check("data_out", bus.data_out, e.data);
                        check("rdy", bus.rdy, e.rdy);
                        check("frame_err", bus.frame_err, e.fe);
                        check("overrun", bus.overrun, e.ov);
                        check_range("latency", lat, 9 * BIT_CLKS, 10 * BIT_CLKS);
                    end
                end
                pd = bus.data_out; pr = bus.rdy; pf = bus.frame_err; po = bus.overrun;
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic seen;
        logic found;
        int   n;
        bus.rx      = 1'b1;
        bus.rdy_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data_out", bus.data_out, 8'h00);
        check("reset_rdy", bus.rdy, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_overrun", bus.overrun, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Plain bytes with reads in between
        send_frame(8'h13, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0);
        wait_drain("b13");
        pulse_clr();
        check("clr_after_13_rdy", bus.rdy, 0);
        send_frame(8'h50, 1'b1, 8'h50, 1'b1, 1'b0, 1'b0);
        wait_drain("b50");
        pulse_clr();
        send_frame(8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        wait_drain("b00");
        pulse_clr();

        // Short low glitch must not start a frame
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (10) @(negedge clk);
        bus.rx = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
        end
        check("glitch_busy_seen", seen, 1);
        check("glitch_busy_end", bus.busy, 0);
        check("glitch_rdy", bus.rdy, 0);
        check("glitch_frame_err", bus.frame_err, 0);
        check("glitch_overrun", bus.overrun, 0);

        // Framing error, then a break held low, then recovery
        send_frame(8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        wait_drain("bA5");
        repeat (64) @(negedge clk);
        check("break_busy_held", bus.busy, 1);
        bus.rx = 1'b1;
        repeat (8) @(negedge clk);
        check("break_release_busy", bus.busy, 0);
        pulse_clr();
        check("clr_frame_err", bus.frame_err, 0);
        send_frame(8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        wait_drain("b3C");
        pulse_clr();

        // Overrun: second byte dropped
        send_frame(8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        wait_drain("b11");
        send_frame(8'h22, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
        wait_drain("b22");
        pulse_clr();
        check("ovr_clr_rdy", bus.rdy, 0);
        check("ovr_clr_overrun", bus.overrun, 0);
        check("ovr_kept_data", bus.data_out, 8'h11);

        // rdy_clr coinciding with the stop decision: frame wins
        send_frame(8'h44, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        wait_drain("b44");
        found = 1'b0;
        fork
            send_frame(8'h77, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
            begin
                n = 0;
                while (!found && n < 400) begin
                    @(negedge clk);
                    n++;
                    if (dut.state_q == STOP && dut.sc_q == 4'd8 && dut.tick) found = 1'b1;
                end
                bus.rdy_clr = found;
                @(negedge clk);
                bus.rdy_clr = 1'b0;
            end
        join
        check("same_cycle_found", found, 1);
        wait_drain("b77");
        check("same_cycle_rdy", bus.rdy, 1);
        check("same_cycle_overrun", bus.overrun, 0);
        check("same_cycle_data", bus.data_out, 8'h77);

        // Reset mid-frame during bit 4 of 8'hFF
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        bus.rx = 1'b1;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        check("pre_reset_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("async_rst_data_out", bus.data_out, 8'h00);
        check("async_rst_rdy", bus.rdy, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_frame_err", bus.frame_err, 0);
        check("async_rst_overrun", bus.overrun, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (400) @(negedge clk);
        check("post_reset_busy", bus.busy, 0);
        check("post_reset_rdy", bus.rdy, 0);
        send_frame(8'h81, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
        wait_drain("b81");

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
